acq_writer: RTL
===============

# acq_writer

Acquisition front-end that turns the ADC sample stream into write transactions for the dual-port acquisition RAM. Once armed, it captures a programmed number of lines. For each line it waits for a trigger, skips a programmed delay, then writes a programmed number of tagged samples to consecutive RAM addresses starting at 0. It drives the RAM write port (`wdata`/`waddr`/`wr`) directly; the host reads the RAM back through the read port once `done` fires.

## Interface
- `ADDR_W`, 13, RAM address width; depth 2**ADDR_W words
- `ADC_W`, 10, ADC sample width
- `DATA_W`, 16, RAM word width; must be ≥ ADC_W+5
- `DLY_W`, 16, delay counter width

- `clk` in 1: system clock; single clock domain
- `rst_n` in 1: reset, asynchronous, active-low
- `adc_data` in ADC_W: ADC sample, valid when `adc_valid`=1
- `adc_valid` in 1: sample strobe, one cycle per sample
- `start` in 1: arm pulse; latches all cfg_* inputs
- `abort` in 1: synchronous cancel, highest priority
- `trig` in 1: line trigger pulse
- `cfg_delay` in DLY_W: samples skipped after each trigger
- `cfg_len` in ADDR_W: samples written per line
- `cfg_lines` in 4: lines per acquisition; 0 means 16
- `wdata` out DATA_W: RAM write data
- `waddr` out ADDR_W: RAM write address
- `wr` out 1: RAM write enable
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle completion pulse
- `line_idx` out 4: index of the line currently being captured
- `ovf` out 1: sticky flag, RAM space exhausted

## Operation
- States: IDLE, WAIT_TRIG, DELAY, CAPTURE.
- IDLE:
  - `start` with `cfg_len`=0: no writes; `done` pulses the next cycle; state stays IDLE.
  - Otherwise `start`: latch config, clear `ovf`, set `line_idx`=0 and the address pointer to 0, go to WAIT_TRIG.
- `start` while busy: ignored.
- WAIT_TRIG:
  - `trig`=1: go to DELAY, or straight to CAPTURE if `cfg_delay`=0.
  - An `adc_valid` in the same cycle as `trig` is discarded.
  - `trig` outside WAIT_TRIG: ignored.
- DELAY: counts `adc_valid` strobes, not clocks. After `cfg_delay` strobes go to CAPTURE; those strobes produce no writes.
- CAPTURE:
  - Each `adc_valid` writes one word at the pointer, then the pointer increments.
  - After `cfg_len` words: if lines remain, increment `line_idx` and return to WAIT_TRIG. Otherwise pulse `done` and go to IDLE.
- `wdata` packing:
  - [ADC_W-1:0] = sample
  - [ADC_W] = 1 on the first sample of each line
  - [ADC_W+4:ADC_W+1] = `line_idx`
  - remaining MSBs = 0
- Overflow: after writing address 2**ADDR_W−1, if more samples are owed, set `ovf`, pulse `done`, go to IDLE. The pointer never wraps.
- `abort`: from any state, go to IDLE the next cycle. Any in-flight `wr` is suppressed, `done` is not pulsed, and `waddr`/`line_idx` keep their values.
- `abort` and `start` in the same cycle: `abort` wins; stay IDLE.

## Timing
- Reset values:
  - `wdata`=0, `waddr`=0, `wr`=0, `busy`=0, `done`=0, `line_idx`=0, `ovf`=0
  - state = IDLE; all counters and latched config = 0
- All outputs are registered.
- `wr` rises exactly 1 cycle after the accepted `adc_valid`, with `waddr`/`wdata` valid in that same cycle. Latency is fixed at 1.
- `busy` rises the cycle after `start` and falls in the same cycle `done` is high.
- `done` is high for exactly one cycle. It coincides with the last `wr` of the acquisition, or with the cycle after the overflow decision.
- Back-to-back `adc_valid` (every cycle) is fully supported; there is no backpressure.
- A `trig` arriving in the same cycle as the last CAPTURE write of a line is ignored; the next line needs a later `trig`.
- `rst_n` asserted mid-acquisition: all outputs go to reset values immediately; no partial `done`.

## Configuration
- `ACQ_WRITER_TESTPATTERN_EN`:
  - Defined: `adc_data` is replaced by an internal ADC_W-bit ramp. The ramp is 0 at each line start and increments on every accepted CAPTURE sample. Tagging and timing are unchanged.
  - Undefined: `adc_data` is written as received. The ramp logic is absent.

## Test plan
- Basic capture: `cfg_lines`=1, `cfg_len`=4, `cfg_delay`=0; `start`, `trig`, then samples 0x011..0x014 → 4 writes at addresses 0..3; word 0 = 0x411, words 1..3 = 0x012..0x014; `done` on the 4th `wr`.
- Delay and multi-line: `cfg_delay`=3, `cfg_len`=2, `cfg_lines`=2 → per line, 3 strobes skipped; addresses 2..3 carry `line_idx`=1 (bit 11 set, bit 10 set on address 2); `done` once.
- Overflow: `ADDR_W`=3, `cfg_len`=6, `cfg_lines`=2 → 8 writes at addresses 0..7, then `ovf`=1 and `done`; no 9th write.
- Abort mid-capture at sample 2 of 4 → no `wr` after the abort cycle, `busy`=0 the next cycle, no `done`; a following `start` clears `ovf` and restarts at address 0.
- Edge cases: `cfg_len`=0 → only `done`, no `wr`; `trig` in IDLE ignored; `adc_valid` coincident with `trig` not written.
- With `ACQ_WRITER_TESTPATTERN_EN`: `cfg_len`=3, 2 lines → data 0x400, 0x001, 0x002, then 0xC00, 0x801, 0x802.

Source files
------------

// File: rtl/acq_writer.sv
// acq_writer: turns the ADC sample stream into RAM write transactions.
// Once armed it captures cfg_lines lines. Each line waits for a trigger,
//   skips cfg_delay strobes, then writes cfg_len tagged samples to
//   consecutive addresses starting at 0.
// Optional feature macro: ACQ_WRITER_TESTPATTERN_EN replaces adc_data with
//   a per-line ramp that restarts at 0 on every line.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   adc_data, adc_valid    sample stream, one strobe per sample
//   start, abort, trig     arm pulse, cancel (highest priority), line trigger
//   cfg_delay/len/lines    configuration, latched on an accepted start
//   wdata, waddr, wr       RAM write port (registered)
//   busy, done, line_idx   status (registered)
//   ovf                    sticky flag, RAM space exhausted
module acq_writer #(
    parameter int ADDR_W = 13,
    parameter int ADC_W  = 10,
    parameter int DATA_W = 16,
    parameter int DLY_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic              adc_valid,
    input  logic              start,
    input  logic              abort,
    input  logic              trig,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [3:0]        cfg_lines,
    output logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] waddr,
    output logic              wr,
    output logic              busy,
    output logic              done,
    output logic [3:0]        line_idx,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        DELAY     = 2'd2,
        CAPTURE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] len_q, len_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [3:0]        lines_q, lines_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0]  dcnt_q, dcnt_d;
    logic [3:0]        line_idx_q, line_idx_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [ADC_W-1:0]  sample;
    logic              trig_ok;
    logic              take;
    logic              line_end;
    logic              last_line;
    logic              ptr_full;
    logic              finish;
    logic              overflow;

`ifdef ACQ_WRITER_TESTPATTERN_EN
    logic [ADC_W-1:0]  ramp_q, ramp_d;
    assign sample = ramp_q;
`else
    assign sample = adc_data;
`endif

    // wr_q high in WAIT_TRIG means the previous line's last word is being
    // written this cycle; a trigger arriving then belongs to no line.
    assign trig_ok   = (state_q == WAIT_TRIG) && trig && !wr_q;
    assign take      = (state_q == CAPTURE) && adc_valid;
    assign line_end  = take && (cnt_q == len_q - 1'b1);
    // lines_q of 0 wraps to 15 here, giving 16 lines
    assign last_line = (line_idx_q == lines_q - 4'd1);
    assign ptr_full  = (ptr_q == '1);
    assign finish    = line_end && last_line;
    assign overflow  = take && ptr_full && !finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && cfg_len != '0) state_d = WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (trig_ok) state_d = (dly_q == '0) ? CAPTURE : DELAY;
                end
                DELAY: begin
                    if (adc_valid && dcnt_q == dly_q - 1'b1) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (finish || overflow) state_d = IDLE;
                    else if (line_end)      state_d = WAIT_TRIG;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        len_d      = len_q;
        dly_d      = dly_q;
        lines_d    = lines_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        line_idx_d = line_idx_q;
        ovf_d      = ovf_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
`ifdef ACQ_WRITER_TESTPATTERN_EN
        ramp_d     = ramp_q;
`endif
        if (!abort) begin
            if (state_q == IDLE && start) begin
                if (cfg_len == '0) begin
                    done_d = 1'b1;
                end else begin
                    len_d      = cfg_len;
                    dly_d      = cfg_delay;
                    lines_d    = cfg_lines;
                    ovf_d      = 1'b0;
                    line_idx_d = 4'd0;
                    ptr_d      = '0;
                end
            end
            if (trig_ok) begin
                dcnt_d = '0;
                cnt_d  = '0;
`ifdef ACQ_WRITER_TESTPATTERN_EN
                ramp_d = '0;
`endif
            end
            if (state_q == DELAY && adc_valid) begin
                dcnt_d = dcnt_q + 1'b1;
            end
            if (take) begin
                wr_d                       = 1'b1;
                waddr_d                    = ptr_q;
                wdata_d                    = '0;
                wdata_d[ADC_W-1:0]         = sample;
                wdata_d[ADC_W]             = (cnt_q == '0);
                wdata_d[ADC_W+4:ADC_W+1]   = line_idx_q;
                cnt_d                      = cnt_q + 1'b1;
                // pointer saturates; a write at the top ends the run
                if (!ptr_full) ptr_d = ptr_q + 1'b1;
`ifdef ACQ_WRITER_TESTPATTERN_EN
                ramp_d                     = ramp_q + 1'b1;
`endif
                if (finish || overflow) begin
                    done_d = 1'b1;
                    if (overflow) ovf_d = 1'b1;
                end else if (line_end) begin
                    line_idx_d = line_idx_q + 4'd1;
                    cnt_d      = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            dly_q      <= '0;
            lines_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            line_idx_q <= '0;
            ovf_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            len_q      <= len_d;
            dly_q      <= dly_d;
            lines_q    <= lines_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            line_idx_q <= line_idx_d;
            ovf_q      <= ovf_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

`ifdef ACQ_WRITER_TESTPATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`endif

    assign wdata    = wdata_q;
    assign waddr    = waddr_q;
    assign wr       = wr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign line_idx = line_idx_q;
    assign ovf      = ovf_q;

endmodule
